// File: rtl/demux_dispatcher.sv
// Sequencing controller for the 1-to-4 demux: holds one word and steers it to a consumer
// chosen by tag or round-robin, with per-channel delivery counters and a sticky stall flag.
module demux_dispatcher_chan_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module demux_dispatcher #(
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              rr_mode,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3,
  output logic              stall_err,
  input  logic              clr_err
);
  localparam int SC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_sel;
  logic [1:0]        r_rr_ptr;
  logic              r_rr_held;
  logic              r_live;
  logic [SC_W-1:0]   r_stall;
  logic              r_err;

  logic                        w_sel_rdy;
  logic                        w_xfer;
  logic                        w_accept;
  logic [1:0]                  w_rr_cur;
  logic [3:0][CNT_W-1:0]       w_cnt;

  assign w_sel_rdy = out_ready[r_sel];
  assign w_xfer    = (r_state == HOLD) & w_sel_rdy;
  assign in_ready  = r_live & ((r_state == IDLE) | w_sel_rdy);
  assign w_accept  = in_valid & in_ready;
  // A round-robin word leaving on the same edge a new one arrives must advance the
  // pointer for the newcomer, otherwise back-to-back words would repeat a channel.
  assign w_rr_cur  = (w_xfer & r_rr_held) ? r_sel + 2'd1 : r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_sel     <= '0;
      r_rr_ptr  <= '0;
      r_rr_held <= 1'b0;
      r_live    <= 1'b0;
      r_stall   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_xfer & r_rr_held) r_rr_ptr <= r_sel + 2'd1;
      if (w_accept) begin
        r_data    <= in_data;
        r_sel     <= rr_mode ? w_rr_cur : in_dest;
        r_rr_held <= rr_mode;
        r_state   <= HOLD;
      end else if (w_xfer) begin
        r_state   <= IDLE;
      end
      if ((r_state == HOLD) && !w_sel_rdy) begin
        if (r_stall != SC_W'(TIMEOUT)) r_stall <= r_stall + 1'b1;
      end else begin
        r_stall <= '0;
      end
      // Set takes priority over clear.
      if (r_stall == SC_W'(TIMEOUT)) r_err <= 1'b1;
      else if (clr_err)              r_err <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < 4; ch++) begin : g_cnt
    demux_dispatcher_chan_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_xfer & (r_sel == 2'(ch))),
      .o_cnt (w_cnt[ch])
    );
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == HOLD) ? (4'b0001 << r_sel) : 4'b0000;
  assign cnt0      = w_cnt[0];
  assign cnt1      = w_cnt[1];
  assign cnt2      = w_cnt[2];
  assign cnt3      = w_cnt[3];
  assign stall_err = r_err;
endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher: tagged, round-robin, backpressure, stall flag,
// counter wrap and asynchronous reset mid-hold.
module tb_demux_dispatcher;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              rr_mode;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3;
  logic              stall_err;
  logic              clr_err;

  int n_chk  = 0;
  int n_fail = 0;

  demux_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .stall_err (stall_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'h0;
    clr_err   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_cnts(input string tag, input int c0, input int c1, input int c2, input int c3);
    chk({tag, " cnt0"}, 64'(cnt0), 64'(c0));
    chk({tag, " cnt1"}, 64'(cnt1), 64'(c1));
    chk({tag, " cnt2"}, 64'(cnt2), 64'(c2));
    chk({tag, " cnt3"}, 64'(cnt3), 64'(c3));
  endtask

  initial begin
    // Reset values, and in_ready held low until the first edge after release.
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = 2'd0;
    rr_mode = 1'b0; out_ready = 4'h0; clr_err = 1'b0;
    #2;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst out_sel", 64'(out_sel), 64'd0);
    chk("rst stall_err", 64'(stall_err), 64'd0);
    chk_cnts("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-release in_ready", 64'(in_ready), 64'd0);
    step();
    chk("first-edge in_ready", 64'(in_ready), 64'd1);

    // Tagged mode, back-to-back to all four channels.
    reset_dut();
    in_valid = 1'b1; rr_mode = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'(10 * (i + 1));
      in_dest = 2'(i);
      step();
      chk("tag out_sel", 64'(out_sel), 64'(i));
      chk("tag out_valid", 64'(out_valid), 64'(4'b0001 << i));
      chk("tag out_data", out_data, 64'(10 * (i + 1)));
      chk("tag in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("tag drained out_valid", 64'(out_valid), 64'd0);
    chk_cnts("tag", 1, 1, 1, 1);

    // Round-robin ignores in_dest.
    reset_dut();
    in_valid = 1'b1; rr_mode = 1'b1; in_dest = 2'd2; in_data = 64'd5; out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr out_sel", 64'(out_sel), 64'(i % 4));
      chk("rr out_valid", 64'(out_valid), 64'(4'b0001 << (i % 4)));
    end
    in_valid = 1'b0;
    step();
    chk_cnts("rr", 2, 2, 1, 1);

    // Backpressure on channel 1 while channel 0 is ready.
    reset_dut();
    in_valid = 1'b1; rr_mode = 1'b0; in_dest = 2'd1; in_data = 64'd99; out_ready = 4'b0001;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", 64'(out_valid), 64'b0010);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp out_data", out_data, 64'd99);
      step();
    end
    out_ready = 4'b0011;
    #1;
    chk("bp ready in_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp done out_valid", 64'(out_valid), 64'd0);
    chk_cnts("bp", 0, 1, 0, 0);
    chk("bp no stall_err", 64'(stall_err), 64'd0);

    // Stall flag with TIMEOUT = 4.
    reset_dut();
    in_valid = 1'b1; in_dest = 2'd3; in_data = 64'd42; out_ready = 4'b0111;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("stall before set", 64'(stall_err), 64'd0);
    step();
    chk("stall set", 64'(stall_err), 64'd1);
    out_ready = 4'b1000;
    step();
    chk("stall delivered cnt3", 64'(cnt3), 64'd1);
    chk("stall sticky", 64'(stall_err), 64'd1);
    step();
    chk("stall sticky idle", 64'(stall_err), 64'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("stall cleared", 64'(stall_err), 64'd0);
    // clr_err held across the set condition: set wins.
    in_valid = 1'b1; out_ready = 4'b0000; clr_err = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("stall clr held before set", 64'(stall_err), 64'd0);
    step();
    chk("stall set beats clr", 64'(stall_err), 64'd1);
    clr_err = 1'b0;
    out_ready = 4'b1000;
    step();
    chk("stall second word cnt3", 64'(cnt3), 64'd2);

    // Counter wrap with CNT_W = 2.
    reset_dut();
    in_valid = 1'b1; in_dest = 2'd0; out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_data = 64'(100 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk_cnts("wrap", 1, 0, 0, 0);

    // Asynchronous reset while a word is held.
    reset_dut();
    in_valid = 1'b1; in_dest = 2'd2; in_data = 64'd7; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    chk("arst held out_valid", 64'(out_valid), 64'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst out_data", out_data, 64'd0);
    chk("arst out_sel", 64'(out_sel), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd0);
    out_ready = 4'hF;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("arst no delivery out_valid", 64'(out_valid), 64'd0);
    chk_cnts("arst", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
